// File: rtl/fp32_div_seq_pkg.sv
// rtl/fp32_div_seq_pkg.sv - binary32 field layout, exponent limits, divider FSM state type
package fp32_div_seq_pkg;

    localparam int FP32_SIGN    = 31;
    localparam int FP32_EXP_HI  = 30;
    localparam int FP32_EXP_LO  = 23;
    localparam int FP32_FRAC_HI = 22;

    localparam logic signed [9:0] FP32_BIAS = 10'sd127;
    localparam logic signed [9:0] FP32_EMIN = -10'sd126;
    localparam logic signed [9:0] FP32_EMAX = 10'sd127;
    localparam logic [31:0]       FP32_INF_POS = 32'h7F80_0000;

    localparam int DIV_STEPS = 26;

    typedef enum logic [3:0] {
        S_IDLE, S_UNPACK, S_SPECIAL, S_NORM_IN, S_PREP, S_DIV, S_NORM_Z,
        S_SHIFT_R, S_ROUND, S_PACK, S_OUT_NAN, S_OUT_INF, S_OUT_ZERO
    } state_t;

    // Denormal/zero fields sit at the minimum exponent; their hidden bit is clear.
    function automatic logic signed [9:0] unbias(input logic [7:0] field);
        return (field == 8'd0) ? FP32_EMIN : $signed({2'b00, field}) - FP32_BIAS;
    endfunction

endpackage

// File: rtl/fp32_div_seq_if.sv
// rtl/fp32_div_seq_if.sv - operand/result handshake bundle shared by the FP datapath units
interface fp32_div_seq_if;

    logic [31:0] din1;
    logic [31:0] din2;
    logic        din_rdy;
    logic [31:0] dout;
    logic        dout_rdy;
    logic        busy;

    modport master (output din1, din2, din_rdy, input dout, dout_rdy, busy);
    modport slave  (input din1, din2, din_rdy, output dout, dout_rdy, busy);

endinterface

// File: rtl/fp_mant_div.sv
// rtl/fp_mant_div.sv - restoring 24-bit mantissa divider, one quotient bit per clock for 26 clocks
module fp_mant_div
    import fp32_div_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [23:0] i_y_m,
    input  logic [23:0] i_rem,
    output logic [25:0] o_q,
    output logic        o_sticky,
    output logic        o_done
);

    // With both mantissas normalised, rem stays below 2*y_m, so 25 bits suffice.
    logic [24:0] r_rem;
    logic [25:0] r_q;
    logic [23:0] r_y;
    logic [4:0]  r_cnt;
    logic        w_ge;
    logic [23:0] w_diff;

    assign w_ge   = r_rem >= {1'b0, r_y};
    assign w_diff = 24'(r_rem - {1'b0, r_y});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem <= '0;
            r_q   <= '0;
            r_y   <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_rem <= {1'b0, i_rem};
            r_y   <= i_y_m;
            r_q   <= '0;
            r_cnt <= 5'(DIV_STEPS);
        end else if (r_cnt != 5'd0) begin
            r_q   <= {r_q[24:0], w_ge};
            r_rem <= w_ge ? {w_diff, 1'b0} : {r_rem[23:0], 1'b0};
            r_cnt <= r_cnt - 5'd1;
        end
    end

    assign o_q      = r_q;
    assign o_sticky = |r_rem;
    assign o_done   = (r_cnt == 5'd1);

endmodule

// File: rtl/fp32_div_seq.sv
// rtl/fp32_div_seq.sv - sequential binary32 divider: FSM, specials, normalise, RNE round, pack
// Optional gradual underflow support: FP32_DIV_DENORM_EN (otherwise flush-to-zero).
module fp32_div_seq
    import fp32_div_seq_pkg::*;
#(
    parameter logic [31:0] NAN_VALUE = 32'hFFFF_FFFF
) (
    input  logic          clk,
    input  logic          rst,
    fp32_div_seq_if.slave bus
);

    state_t            r_state, w_next;
    logic [31:0]       r_a, r_b, r_dout;
    logic              r_dout_rdy, r_z_s, r_g, r_r, r_s;
    logic signed [9:0] r_x_e, r_y_e, r_z_e, w_ze_n;
    logic [23:0]       r_x_m, r_y_m, r_mant;
    logic [25:0]       w_q, w_q_n;
    logic              w_sticky, w_done, w_start;
    logic              w_x_nan, w_y_nan, w_x_inf, w_y_inf, w_x_zero, w_y_zero;
    logic              w_inc;
    logic [24:0]       w_sum;
    logic [7:0]        w_field;

    fp_mant_div u_mant_div (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_y_m    (r_y_m),
        .i_rem    (r_x_m),
        .o_q      (w_q),
        .o_sticky (w_sticky),
        .o_done   (w_done)
    );

    assign w_x_nan = (&r_a[FP32_EXP_HI:FP32_EXP_LO]) & (|r_a[FP32_FRAC_HI:0]);
    assign w_y_nan = (&r_b[FP32_EXP_HI:FP32_EXP_LO]) & (|r_b[FP32_FRAC_HI:0]);
    assign w_x_inf = (&r_a[FP32_EXP_HI:FP32_EXP_LO]) & ~(|r_a[FP32_FRAC_HI:0]);
    assign w_y_inf = (&r_b[FP32_EXP_HI:FP32_EXP_LO]) & ~(|r_b[FP32_FRAC_HI:0]);
`ifdef FP32_DIV_DENORM_EN
    assign w_x_zero = ~(|r_a[FP32_EXP_HI:0]);
    assign w_y_zero = ~(|r_b[FP32_EXP_HI:0]);
`else
    assign w_x_zero = ~(|r_a[FP32_EXP_HI:FP32_EXP_LO]);
    assign w_y_zero = ~(|r_b[FP32_EXP_HI:FP32_EXP_LO]);
`endif

    // Quotient below 1.0 is renormalised in the same cycle it is captured.
    assign w_q_n   = w_q[25] ? w_q : {w_q[24:0], 1'b0};
    assign w_ze_n  = w_q[25] ? r_z_e : r_z_e - 10'sd1;
    assign w_inc   = r_g & (r_r | r_s | r_mant[0]);
    assign w_sum   = {1'b0, r_mant} + {24'd0, w_inc};
    assign w_field = 8'(r_z_e + FP32_BIAS);
    assign w_start = (r_state == S_PREP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (bus.din_rdy) w_next = S_UNPACK;
            S_UNPACK:  w_next = S_SPECIAL;
            S_SPECIAL: begin
                if (w_x_nan || w_y_nan || (w_x_inf && w_y_inf) || (w_x_zero && w_y_zero))
                    w_next = S_OUT_NAN;
                else if (w_x_inf || w_y_zero)
                    w_next = S_OUT_INF;
                else if (w_x_zero || w_y_inf)
                    w_next = S_OUT_ZERO;
`ifdef FP32_DIV_DENORM_EN
                else if (!r_x_m[23] || !r_y_m[23])
                    w_next = S_NORM_IN;
`endif
                else
                    w_next = S_PREP;
            end
`ifdef FP32_DIV_DENORM_EN
            S_NORM_IN: if ((r_x_m[23] || r_x_m[22]) && (r_y_m[23] || r_y_m[22])) w_next = S_PREP;
            S_SHIFT_R: if (r_z_e == FP32_EMIN - 10'sd1) w_next = S_ROUND;
`endif
            S_PREP:    w_next = S_DIV;
            S_DIV:     if (w_done) w_next = S_NORM_Z;
            S_NORM_Z: begin
                if (w_ze_n > FP32_EMAX)
                    w_next = S_OUT_INF;
`ifdef FP32_DIV_DENORM_EN
                else if (w_ze_n < FP32_EMIN - 10'sd24)
                    w_next = S_OUT_ZERO;
                else if (w_ze_n < FP32_EMIN)
                    w_next = S_SHIFT_R;
`else
                else if (w_ze_n < FP32_EMIN)
                    w_next = S_OUT_ZERO;
`endif
                else
                    w_next = S_ROUND;
            end
            S_ROUND:   w_next = S_PACK;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a <= '0;  r_b <= '0;  r_dout <= '0;  r_dout_rdy <= 1'b0;
            r_z_s <= 1'b0;  r_g <= 1'b0;  r_r <= 1'b0;  r_s <= 1'b0;
            r_x_e <= '0;  r_y_e <= '0;  r_z_e <= '0;
            r_x_m <= '0;  r_y_m <= '0;  r_mant <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.din_rdy) begin
                    r_a        <= bus.din1;
                    r_b        <= bus.din2;
                    r_dout     <= '0;
                    r_dout_rdy <= 1'b0;
                end
                S_UNPACK: begin
                    r_x_e <= unbias(r_a[FP32_EXP_HI:FP32_EXP_LO]);
                    r_y_e <= unbias(r_b[FP32_EXP_HI:FP32_EXP_LO]);
                    r_x_m <= {|r_a[FP32_EXP_HI:FP32_EXP_LO], r_a[FP32_FRAC_HI:0]};
                    r_y_m <= {|r_b[FP32_EXP_HI:FP32_EXP_LO], r_b[FP32_FRAC_HI:0]};
                    r_z_s <= r_a[FP32_SIGN] ^ r_b[FP32_SIGN];
                end
`ifdef FP32_DIV_DENORM_EN
                S_NORM_IN: begin
                    if (!r_x_m[23]) begin
                        r_x_m <= r_x_m << 1;
                        r_x_e <= r_x_e - 10'sd1;
                    end
                    if (!r_y_m[23]) begin
                        r_y_m <= r_y_m << 1;
                        r_y_e <= r_y_e - 10'sd1;
                    end
                end
                S_SHIFT_R: begin
                    {r_mant, r_g, r_r} <= {1'b0, r_mant, r_g};
                    r_s   <= r_s | r_r;
                    r_z_e <= r_z_e + 10'sd1;
                end
`endif
                S_PREP: r_z_e <= r_x_e - r_y_e;
                S_NORM_Z: begin
                    r_z_e  <= w_ze_n;
                    r_mant <= w_q_n[25:2];
                    r_g    <= w_q_n[1];
                    r_r    <= w_q_n[0];
                    r_s    <= w_sticky;
                end
                S_ROUND: begin
                    if (w_sum[24]) begin
                        r_mant <= 24'h80_0000;
                        r_z_e  <= r_z_e + 10'sd1;
                    end else begin
                        r_mant <= w_sum[23:0];
                    end
                end
                S_PACK: begin
                    r_dout_rdy <= 1'b1;
                    if (r_z_e > FP32_EMAX)
                        r_dout <= {r_z_s, FP32_INF_POS[30:0]};
                    else
                        r_dout <= {r_z_s, r_mant[23] ? w_field : 8'd0, r_mant[22:0]};
                end
                S_OUT_NAN: begin
                    r_dout     <= NAN_VALUE;
                    r_dout_rdy <= 1'b1;
                end
                S_OUT_INF: begin
                    r_dout     <= {r_z_s, FP32_INF_POS[30:0]};
                    r_dout_rdy <= 1'b1;
                end
                S_OUT_ZERO: begin
                    r_dout     <= {r_z_s, 31'd0};
                    r_dout_rdy <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.dout     = r_dout;
    assign bus.dout_rdy = r_dout_rdy;
    assign bus.busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_fp32_div_seq.sv
// tb/tb_fp32_div_seq.sv - scoreboard bench for fp32_div_seq: directed vectors, latency, handshake, reset
module tb_fp32_div_seq;

    typedef struct {
        logic [31:0] val;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    fp32_div_seq_if bus ();

    fp32_div_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // lat < 0 means the latency of that result is not checked.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
        int n = 0;
        while (bus.busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_before_accept", 32'(bus.busy), 32'd0);
        bus.din1    = a;
        bus.din2    = b;
        bus.din_rdy = 1'b1;
        @(posedge clk); #1;
        bus.din_rdy = 1'b0;
        sb_q.push_back('{val: exp, lat: lat, acc: cyc});
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        check("rdy_after_accept", 32'(bus.dout_rdy), 32'd0);
        check("dout_after_accept", bus.dout, 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d results pending, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin : monitor
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.dout_rdy && !prev) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got 0x%08h, required no result", bus.dout);
                end else begin
                    e = sb_q.pop_front();
                    check("dout", bus.dout, e.val);
                    if (e.lat >= 0) check("latency", 32'(cyc - e.acc), 32'(e.lat));
                end
            end
            prev = bus.dout_rdy;
        end
    end

    initial begin : stimulus
        int n;
        bus.din1    = '0;
        bus.din2    = '0;
        bus.din_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_dout", bus.dout, 32'd0);
        check("reset_rdy", 32'(bus.dout_rdy), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 32);
        issue(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 32);
        issue(32'hBF80_0000, 32'h4040_0000, 32'hBEAA_AAAB, 32);
        issue(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 3);
        issue(32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 3);
        issue(32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 3);
        issue(32'h7F80_0000, 32'h7F80_0000, 32'hFFFF_FFFF, 3);
        issue(32'h7FC0_0000, 32'h3F80_0000, 32'hFFFF_FFFF, 3);
        issue(32'h0000_0000, 32'hC000_0000, 32'h8000_0000, 3);
        issue(32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000, 3);
        issue(32'h7F7F_FFFF, 32'h3F00_0000, 32'h7F80_0000, -1);
`ifdef FP32_DIV_DENORM_EN
        issue(32'h0080_0000, 32'h4000_0000, 32'h0040_0000, 33);
        issue(32'h0040_0000, 32'h0080_0000, 32'h3F00_0000, 33);
`else
        issue(32'h0080_0000, 32'h4000_0000, 32'h0000_0000, -1);
        issue(32'h0040_0000, 32'h0080_0000, 32'h0000_0000, 3);
`endif
        drain();

        // A din_rdy pulse mid-operation must not disturb the result.
        issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 32);
        repeat (5) begin @(posedge clk); #1; end
        bus.din1    = 32'h3F80_0000;
        bus.din2    = 32'h4040_0000;
        bus.din_rdy = 1'b1;
        @(posedge clk); #1;
        bus.din_rdy = 1'b0;
        drain();
        repeat (40) begin @(posedge clk); #1; end

        // din_rdy held high: second operation starts the cycle after dout_rdy rises.
        bus.din1    = 32'h3F80_0000;
        bus.din2    = 32'h4040_0000;
        bus.din_rdy = 1'b1;
        @(posedge clk); #1;
        sb_q.push_back('{val: 32'h3EAA_AAAB, lat: 32, acc: cyc});
        n = 0;
        while (!bus.dout_rdy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("hold_first_done", 32'(bus.dout_rdy), 32'd1);
        @(posedge clk); #1;
        sb_q.push_back('{val: 32'h3EAA_AAAB, lat: 32, acc: cyc});
        check("hold_second_accept", 32'(bus.busy), 32'd1);
        bus.din_rdy = 1'b0;
        drain();

        // Reset in the middle of DIV aborts the operation immediately.
        issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 32);
        repeat (10) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        sb_q.delete();
        check("midrst_dout", bus.dout, 32'd0);
        check("midrst_rdy", 32'(bus.dout_rdy), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        issue(32'hBF80_0000, 32'h4040_0000, 32'hBEAA_AAAB, 32);
        drain();
        repeat (40) begin @(posedge clk); #1; end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
